// File: rtl/ntru_decrypt_coeff_unit_if.sv
// Handshake bundle between the coefficient sequencer, the decrypt coefficient unit and the message buffer.
// The DUT takes the slave modport and the producer/consumer side takes master.
interface ntru_decrypt_coeff_unit_if #(
    parameter int NUM_WIDTH_LENGTH = 13
);
    logic [NUM_WIDTH_LENGTH-1:0] c_in;
    logic                        f_nz;
    logic                        f_neg;
    logic                        in_last;
    logic                        in_valid;
    logic                        in_ready;
    logic [1:0]                  out_trit;
    logic [NUM_WIDTH_LENGTH-1:0] out_acc;
    logic                        out_err;
    logic                        out_valid;
    logic                        out_ready;

    modport slave (
        input  c_in, f_nz, f_neg, in_last, in_valid, out_ready,
        output in_ready, out_trit, out_acc, out_err, out_valid
    );

    modport master (
        output c_in, f_nz, f_neg, in_last, in_valid, out_ready,
        input  in_ready, out_trit, out_acc, out_err, out_valid
    );
endinterface

// File: rtl/ntru_decrypt_coeff_unit.sv
// Accumulates one coefficient of c*f mod q and center-lifts it. The result is folded mod 3
// two bits per cycle and emitted as one message trit per frame.
module ntru_decrypt_coeff_unit #(
    parameter int NUM_WIDTH_LENGTH = 13,
    parameter int N_COEF           = 701,
    parameter int CNT_W            = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    ntru_decrypt_coeff_unit_if.slave    bus
);
    localparam int W     = NUM_WIDTH_LENGTH;
    localparam int NDIG  = (W + 1) / 2;
    localparam int DIG_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    // Center lift subtracts q, so the residue shifts by -(q mod 3): +1 for odd W, +2 for even W
    localparam logic [2:0]       LIFT  = (W % 2 == 1) ? 3'd1 : 3'd2;
    localparam logic [CNT_W:0]   N_CNT = (CNT_W+1)'(N_COEF);

    typedef enum logic [1:0] {ACC, FOLD, OUT} state_t;

    state_t               r_state, w_next;
    logic [W-1:0]         r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic [1:0]           r_res;
    logic [DIG_W-1:0]     r_dig;
    logic                 r_err;
    logic [1:0]           r_trit;
    logic [W-1:0]         r_out_acc;
    logic                 r_out_err;
    logic                 r_out_valid;

    logic                 w_accept;
    logic [W-1:0]         w_addend;
    logic [CNT_W-1:0]     w_cnt_inc;
    logic                 w_frame_err;
    logic [1:0]           w_d;
    logic [2:0]           w_sum;
    logic [1:0]           w_res_nx;
    logic [2:0]           w_lift_sum;
    logic [1:0]           w_r3;
    logic                 w_last_dig;

    assign w_accept    = bus.in_valid && (r_state == ACC);
    assign w_addend    = bus.f_neg ? (~bus.c_in + W'(1)) : bus.c_in;
    assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_frame_err = (({1'b0, r_cnt} + (CNT_W+1)'(1)) != N_CNT);

    // 4 == 1 mod 3, so each 2-bit digit of acc contributes its plain value to the residue
    assign w_d        = 2'(r_acc >> {r_dig, 1'b0});
    assign w_sum      = 3'(r_res) + 3'(w_d);
    assign w_res_nx   = 2'((w_sum >= 3'd3) ? w_sum - 3'd3 : w_sum);
    assign w_lift_sum = 3'(w_res_nx) + LIFT;
    assign w_r3       = r_acc[W-1] ? 2'((w_lift_sum >= 3'd3) ? w_lift_sum - 3'd3 : w_lift_sum)
                                   : w_res_nx;
    assign w_last_dig = (r_dig == DIG_W'(NDIG - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= ACC;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ACC:     if (w_accept && bus.in_last) w_next = FOLD;
            FOLD:    if (w_last_dig)              w_next = OUT;
            OUT:     if (bus.out_ready)           w_next = ACC;
            default:                              w_next = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_res       <= '0;
            r_dig       <= '0;
            r_err       <= 1'b0;
            r_trit      <= 2'b00;
            r_out_acc   <= '0;
            r_out_err   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ACC: if (w_accept) begin
                    if (bus.f_nz) r_acc <= r_acc + w_addend;
                    r_cnt <= w_cnt_inc;
                    if (bus.in_last) begin
                        r_err <= w_frame_err;
                        r_res <= '0;
                        r_dig <= '0;
                    end
                end
                FOLD: begin
                    r_res <= w_res_nx;
                    r_dig <= r_dig + DIG_W'(1);
                    if (w_last_dig) begin
                        r_trit      <= {w_r3 == 2'd2, w_r3 == 2'd1};
                        r_out_acc   <= r_acc;
                        r_out_err   <= r_err;
                        r_out_valid <= 1'b1;
                    end
                end
                OUT: if (bus.out_ready) begin
                    r_out_valid <= 1'b0;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ACC);
    assign bus.out_trit  = r_trit;
    assign bus.out_acc   = r_out_acc;
    assign bus.out_err   = r_out_err;
    assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_ntru_decrypt_coeff_unit.sv
// Bench for the decrypt coefficient unit: directed frames, backpressure, error/reset cases and
// random frames against an integer reference (signed sum mod q, center-lift, residue mod 3).
module tb_ntru_decrypt_coeff_unit;
    localparam int W  = 13;
    localparam int NC = 4;
    localparam int Q  = 1 << W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ntru_decrypt_coeff_unit_if #(.NUM_WIDTH_LENGTH(W)) ifc();

    ntru_decrypt_coeff_unit #(.NUM_WIDTH_LENGTH(W), .N_COEF(NC), .CNT_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    int checks = 0;
    int errors = 0;
    int bc[$];
    int bt[$];
    logic [1:0]   got_trit;
    logic [W-1:0] got_acc;
    logic         got_err;
    int           got_lat;
    logic [1:0]   exp_trit;
    int           exp_cen;
    logic         exp_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input int c, input int t, input bit last, input bit gaps);
        int w;
        if (gaps) repeat ($urandom_range(0, 2)) tick();
        ifc.c_in     = W'(c);
        ifc.f_nz     = (t != 0);
        ifc.f_neg    = (t < 0);
        ifc.in_last  = last;
        ifc.in_valid = 1'b1;
        w = 0;
        while (!ifc.in_ready && w < 200) begin
            tick();
            w++;
        end
        if (w >= 200) begin
            errors++;
            $display("FAIL beat_accept_timeout: in_ready stayed %b, required 1", ifc.in_ready);
        end
        tick();
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
    endtask

    task automatic wait_result();
        got_lat = 0;
        while (!ifc.out_valid && got_lat < 50) begin
            tick();
            got_lat++;
        end
        got_trit = ifc.out_trit;
        got_acc  = ifc.out_acc;
        got_err  = ifc.out_err;
    endtask

    task automatic play_frame(input bit gaps);
        foreach (bc[i]) drive_beat(bc[i], bt[i], i == bc.size() - 1, gaps);
        wait_result();
    endtask

    task automatic consume(input int delay);
        repeat (delay) tick();
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
    endtask

    // Reference: plain signed integer arithmetic, no bit-level folding
    task automatic model();
        int s;
        int m;
        s = 0;
        foreach (bc[i]) s += bt[i] * bc[i];
        s = ((s % Q) + Q) % Q;
        exp_cen = (s >= Q / 2) ? s - Q : s;
        m = ((exp_cen % 3) + 3) % 3;
        exp_trit = (m == 1) ? 2'b01 : (m == 2) ? 2'b10 : 2'b00;
        exp_err  = (bc.size() != NC);
    endtask

    function automatic int cen_of(input logic [W-1:0] a);
        int v;
        v = $signed(a);
        return v;
    endfunction

    task automatic test_reset();
        checks++; if (ifc.in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready: got %b want 1", ifc.in_ready); end
        checks++; if (ifc.out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid: got %b want 0", ifc.out_valid); end
        checks++; if (ifc.out_trit !== 2'b00)  begin errors++; $display("FAIL reset_out_trit: got %b want 00", ifc.out_trit); end
        checks++; if (ifc.out_acc !== '0)      begin errors++; $display("FAIL reset_out_acc: got %0d want 0", ifc.out_acc); end
        checks++; if (ifc.out_err !== 1'b0)    begin errors++; $display("FAIL reset_out_err: got %b want 0", ifc.out_err); end
    endtask

    task automatic test_directed();
        int tc[4][4]  = '{'{5, 3, 10, 1}, '{4096, 0, 0, 0}, '{8191, 8191, 0, 0}, '{1, 0, 0, 0}};
        int tt[4][4]  = '{'{1, -1, 0, 1}, '{1, 1, 0, -1}, '{1, 1, 0, 0}, '{-1, 0, 0, 0}};
        int ecen[4]   = '{3, -4096, -2, -1};
        logic [1:0] etr[4] = '{2'b00, 2'b10, 2'b01, 2'b10};
        for (int k = 0; k < 4; k++) begin
            bc.delete(); bt.delete();
            for (int j = 0; j < 4; j++) begin bc.push_back(tc[k][j]); bt.push_back(tt[k][j]); end
            play_frame(1'b0);
            checks++; if (got_lat != 7)               begin errors++; $display("FAIL dir%0d_latency: got %0d want 7", k, got_lat); end
            checks++; if (cen_of(got_acc) != ecen[k]) begin errors++; $display("FAIL dir%0d_out_acc: got %0d want %0d", k, cen_of(got_acc), ecen[k]); end
            checks++; if (got_trit !== etr[k])        begin errors++; $display("FAIL dir%0d_out_trit: got %b want %b", k, got_trit, etr[k]); end
            checks++; if (got_err !== 1'b0)           begin errors++; $display("FAIL dir%0d_out_err: got %b want 0", k, got_err); end
            consume(0);
        end
    endtask

    task automatic test_backpressure();
        bc = '{4096, 0, 0, 0}; bt = '{1, 1, 0, -1};
        model();
        play_frame(1'b0);
        for (int i = 0; i < 5; i++) begin
            ifc.c_in = W'(777); ifc.f_nz = 1'b1; ifc.f_neg = 1'b0; ifc.in_last = 1'b1; ifc.in_valid = 1'b1;
            tick();
            checks++;
            if (ifc.out_valid !== 1'b1 || ifc.in_ready !== 1'b0 || ifc.out_trit !== exp_trit ||
                cen_of(ifc.out_acc) != exp_cen || ifc.out_err !== exp_err) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b rdy=%b trit=%b acc=%0d err=%b want v=1 rdy=0 trit=%b acc=%0d err=%b",
                         i, ifc.out_valid, ifc.in_ready, ifc.out_trit, cen_of(ifc.out_acc), ifc.out_err,
                         exp_trit, exp_cen, exp_err);
            end
        end
        ifc.in_valid = 1'b0; ifc.in_last = 1'b0;
        consume(0);
        checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", ifc.out_valid); end
        checks++; if (ifc.in_ready !== 1'b1)  begin errors++; $display("FAIL bp_release_ready: got %b want 1", ifc.in_ready); end
        bc = '{5, 3, 10, 1}; bt = '{1, -1, 0, 1};
        model();
        play_frame(1'b0);
        checks++; if (cen_of(got_acc) != exp_cen) begin errors++; $display("FAIL bp_next_acc: got %0d want %0d", cen_of(got_acc), exp_cen); end
        checks++; if (got_trit !== exp_trit)      begin errors++; $display("FAIL bp_next_trit: got %b want %b", got_trit, exp_trit); end
        consume(1);
    endtask

    task automatic test_err_and_reset();
        int seen;
        bc = '{7, 1}; bt = '{1, 1};
        model();
        play_frame(1'b0);
        checks++; if (got_err !== 1'b1)      begin errors++; $display("FAIL short_err: got %b want 1", got_err); end
        checks++; if (got_trit !== 2'b10)    begin errors++; $display("FAIL short_trit: got %b want 10", got_trit); end
        checks++; if (got_lat != 7)          begin errors++; $display("FAIL short_latency: got %0d want 7", got_lat); end
        consume(0);
        bc = '{100, 200, 300, 400}; bt = '{1, 1, 1, -1};
        foreach (bc[i]) drive_beat(bc[i], bt[i], i == 3, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL rst_fold_valid: got %b want 0", ifc.out_valid); end
        checks++; if (ifc.in_ready !== 1'b1)  begin errors++; $display("FAIL rst_fold_ready: got %b want 1", ifc.in_ready); end
        checks++; if (ifc.out_acc !== '0)     begin errors++; $display("FAIL rst_fold_acc: got %0d want 0", ifc.out_acc); end
        seen = 0;
        repeat (10) begin tick(); if (ifc.out_valid) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL rst_fold_no_result: out_valid high %0d cycles, want 0", seen); end
        bc = '{8000, 123, 4095, 9}; bt = '{-1, 1, 1, 0};
        model();
        play_frame(1'b0);
        checks++;
        if (cen_of(got_acc) != exp_cen || got_trit !== exp_trit || got_err !== exp_err) begin
            errors++;
            $display("FAIL rst_next_frame: got acc=%0d trit=%b err=%b want acc=%0d trit=%b err=%b",
                     cen_of(got_acc), got_trit, got_err, exp_cen, exp_trit, exp_err);
        end
        consume(0);
    endtask

    task automatic test_random();
        int len;
        int r;
        for (int f = 0; f < 1000; f++) begin
            bc.delete(); bt.delete();
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : NC;
            for (int j = 0; j < len; j++) begin
                r = $urandom_range(0, 7);
                bc.push_back(r == 0 ? 0 : r == 1 ? Q - 1 : r == 2 ? Q / 2 : r == 3 ? Q / 2 - 1
                             : int'($urandom_range(0, Q - 1)));
                bt.push_back(int'($urandom_range(0, 2)) - 1);
            end
            model();
            play_frame(1'b1);
            checks++;
            if (got_lat != 7 || cen_of(got_acc) != exp_cen || got_trit !== exp_trit || got_err !== exp_err) begin
                errors++;
                $display("FAIL rand%0d: got lat=%0d acc=%0d trit=%b err=%b want lat=7 acc=%0d trit=%b err=%b",
                         f, got_lat, cen_of(got_acc), got_trit, got_err, exp_cen, exp_trit, exp_err);
            end
            consume($urandom_range(0, 3));
        end
    endtask

    initial begin
        ifc.c_in = '0; ifc.f_nz = 1'b0; ifc.f_neg = 1'b0; ifc.in_last = 1'b0;
        ifc.in_valid = 1'b0; ifc.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_err_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
